// File: rtl/go_token_source_if.sv
// Go/done token channels between the token source (master) and the compute block (slave).
interface go_token_source_if;
   logic sourceGo_d;
   logic sourceGo_r;
   logic doneGo_d;
   logic doneGo_r;

   modport master (
      output sourceGo_d,
      input  sourceGo_r,
      input  doneGo_d,
      output doneGo_r
   );

   modport slave (
      input  sourceGo_d,
      output sourceGo_r,
      output doneGo_d,
      input  doneGo_r
   );
endinterface

// File: rtl/go_token_source.sv
// Issues NUM_TOKENS Go tokens per start pulse under a credit limit and optional spacing,
// tracking returned completions; every output is registered.
module go_token_source #(
   parameter int unsigned NUM_TOKENS      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned GAP             = 0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   go_token_source_if.master io_go,
   output logic              o_busy,
   output logic              o_finished,
   output logic [15:0]       o_issued_cnt,
   output logic [7:0]        o_outstanding,
   output logic              o_err
);
   localparam logic [15:0] L_NUM = 16'(NUM_TOKENS);
   localparam logic [7:0]  L_MAX = 8'(MAX_OUTSTANDING);
   localparam logic [7:0]  L_GAP = 8'(GAP);

   typedef enum logic [1:0] {StIdle, StIssue, StGapWait, StDrain} state_e;

   state_e      r_state;
   logic        r_valid;
   logic        r_done_rdy;
   logic        r_busy;
   logic        r_finished;
   logic        r_err;
   logic [15:0] r_issued;
   logic [7:0]  r_outstanding;
   logic [7:0]  r_gap_cnt;

   logic        w_xfer;
   logic        w_cpl;
   logic        w_underflow;
   logic        w_last;
   logic        w_credit;
   logic [15:0] w_issued_inc;
   logic [7:0]  w_out_nxt;

   assign w_xfer       = r_valid & io_go.sourceGo_r;
   assign w_cpl        = io_go.doneGo_d & r_done_rdy;
   assign w_underflow  = w_cpl & (r_outstanding == 8'd0);
   assign w_issued_inc = (r_issued == 16'hffff) ? r_issued : r_issued + 16'd1;
   assign w_last       = (w_issued_inc == L_NUM);

   // An underflowing completion is dropped, so it never cancels a same-edge issue.
   always_comb begin
      w_out_nxt = r_outstanding;
      case ({w_xfer, w_cpl & ~w_underflow})
         2'b10:   if (r_outstanding != 8'hff) w_out_nxt = r_outstanding + 8'd1;
         2'b01:   w_out_nxt = r_outstanding - 8'd1;
         default: w_out_nxt = r_outstanding;
      endcase
   end

   // Credit is judged on the post-edge count so a freed slot re-raises valid next cycle.
   assign w_credit = (w_out_nxt < L_MAX);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_valid       <= 1'b0;
         r_done_rdy    <= 1'b0;
         r_busy        <= 1'b0;
         r_finished    <= 1'b0;
         r_err         <= 1'b0;
         r_issued      <= 16'd0;
         r_outstanding <= 8'd0;
         r_gap_cnt     <= 8'd0;
      end else begin
         r_done_rdy    <= 1'b1;
         r_outstanding <= w_out_nxt;
         r_finished    <= 1'b0;
         if (w_underflow) r_err <= 1'b1;
         if (w_xfer) r_issued <= w_issued_inc;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_state  <= StIssue;
                  r_busy   <= 1'b1;
                  r_valid  <= w_credit;
                  r_issued <= 16'd0;
                  r_err    <= w_underflow;
               end
            end
            StIssue: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_state <= StDrain;
                     r_valid <= 1'b0;
                  end else if (L_GAP != 8'd0) begin
                     r_state   <= StGapWait;
                     r_gap_cnt <= L_GAP - 8'd1;
                     r_valid   <= 1'b0;
                  end else begin
                     r_valid <= w_credit;
                  end
               end else if (!r_valid) begin
                  r_valid <= w_credit;
               end
            end
            StGapWait: begin
               if (r_gap_cnt == 8'd0) begin
                  r_state <= StIssue;
                  r_valid <= w_credit;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
               end
            end
            StDrain: begin
               if (w_out_nxt == 8'd0) begin
                  r_state    <= StIdle;
                  r_busy     <= 1'b0;
                  r_finished <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_go.sourceGo_d = r_valid;
   assign io_go.doneGo_r   = r_done_rdy;
   assign o_busy           = r_busy;
   assign o_finished       = r_finished;
   assign o_issued_cnt     = r_issued;
   assign o_outstanding    = r_outstanding;
   assign o_err            = r_err;
endmodule

// File: tb/tb_go_token_source.sv
// Two DUT lanes (default params; GAP=2/MAX=8/N=3) driven by random consumers and checked
// against a rule-level model: transfers and finished pulses go through scoreboard queues.
module tb_go_token_source;
   localparam int Lanes = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-lane stimulus controls and published model state.
   bit start_req [Lanes];
   bit rdy_rand  [Lanes];
   int rdy_hold  [Lanes];
   int dly_lo    [Lanes];
   int dly_hi    [Lanes];
   bit spur      [Lanes];
   bit m_active_v[Lanes];
   int m_issued_v[Lanes];
   int m_out_v   [Lanes];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   for (genvar k = 0; k < Lanes; k++) begin : g_lane
      localparam int N    = (k == 0) ? 4 : 3;
      localparam int MaxO = (k == 0) ? 2 : 8;
      localparam int Gap  = (k == 0) ? 0 : 2;

      go_token_source_if bus ();
      logic        start;
      logic        busy;
      logic        fin;
      logic        err;
      logic [15:0] issued;
      logic [7:0]  outst;

      go_token_source #(
         .NUM_TOKENS     (N),
         .MAX_OUTSTANDING(MaxO),
         .GAP            (Gap)
      ) dut (
         .i_clk        (clk),
         .i_reset      (rst),
         .i_start      (start),
         .io_go        (bus),
         .o_busy       (busy),
         .o_finished   (fin),
         .o_issued_cnt (issued),
         .o_outstanding(outst),
         .o_err        (err)
      );

      // Reference model: counts of tokens issued/outstanding plus the earliest cycle at which
      // the next token may be offered (start edge, or last transfer edge + Gap).
      bit m_active, m_valid, m_rdy, m_err;
      int m_issued, m_out, m_earliest;
      bit xf, cp, un;
      int e;
      int exp_xfer[$];
      int exp_cnt[$];
      int exp_fin[$];
      int cpl_due[$];
      int seen[$];
      int max_out = 0;
      int both_cnt = 0;

      initial begin
         start = 1'b0;
         bus.sourceGo_r = 1'b0;
         bus.doneGo_d = 1'b0;
         {m_active, m_valid, m_rdy, m_err} = 4'b0;
         m_issued = 0;
         m_out = 0;
         m_earliest = 0;
         forever begin
            @(posedge clk);
            #1;
            e = cyc;
            if (rst) begin
               {m_active, m_valid, m_rdy, m_err} = 4'b0;
               m_issued = 0;
               m_out = 0;
               exp_xfer.delete();
               exp_cnt.delete();
               exp_fin.delete();
               cpl_due.delete();
               start = 1'b0;
               bus.sourceGo_r = 1'b0;
               bus.doneGo_d = 1'b0;
            end else begin
               xf = m_valid && bus.sourceGo_r;
               cp = bus.doneGo_d && m_rdy;
               un = cp && (m_out == 0);
               if (un) m_err = 1'b1;
               m_out = m_out + int'(xf) - int'(cp && !un);
               if (!m_active && start) begin
                  m_active = 1'b1;
                  m_issued = 0;
                  m_err = un;
                  m_earliest = e;
               end
               if (xf) begin
                  m_issued++;
                  m_earliest = e + Gap;
                  cpl_due.push_back(e + int'($urandom_range(dly_hi[k], dly_lo[k])));
               end
               if (m_active && m_issued == N && m_out == 0) begin
                  m_active = 1'b0;
                  exp_fin.push_back(e);
               end
               m_rdy = 1'b1;
               m_valid = m_active && (m_issued < N) && (e >= m_earliest) && (m_out < MaxO);
               // Inputs for the cycle that follows edge e.
               start = start_req[k];
               start_req[k] = 1'b0;
               if (rdy_hold[k] > 0 && m_valid) begin
                  bus.sourceGo_r = 1'b0;
                  rdy_hold[k]--;
               end else if (rdy_rand[k]) begin
                  bus.sourceGo_r = 1'($urandom_range(1, 0));
               end else begin
                  bus.sourceGo_r = 1'b1;
               end
               if (spur[k]) begin
                  bus.doneGo_d = 1'b1;
                  spur[k] = 1'b0;
               end else if (cpl_due.size() > 0 && cpl_due[0] <= e + 1) begin
                  bus.doneGo_d = 1'b1;
                  void'(cpl_due.pop_front());
               end else begin
                  bus.doneGo_d = 1'b0;
               end
               if (m_valid && bus.sourceGo_r) begin
                  exp_xfer.push_back(e + 1);
                  exp_cnt.push_back(m_issued + 1);
               end
            end
            m_active_v[k] = m_active;
            m_issued_v[k] = m_issued;
            m_out_v[k] = m_out;
         end
      end

      // Monitor: samples mid-cycle, pops the scoreboard on DUT transfers and finished pulses.
      int pend_cnt = -1;
      initial begin
         forever begin
            @(negedge clk);
            if (rst) begin
               pend_cnt = -1;
            end else begin
               if (pend_cnt >= 0) begin
                  chk($sformatf("issued_after_xfer[%0d]", k), int'(issued), pend_cnt);
                  pend_cnt = -1;
               end
               chk($sformatf("busy[%0d]", k), int'(busy), int'(m_active));
               chk($sformatf("go_valid[%0d]", k), int'(bus.sourceGo_d), int'(m_valid));
               chk($sformatf("outstanding[%0d]", k), int'(outst), m_out);
               chk($sformatf("err[%0d]", k), int'(err), int'(m_err));
               chk($sformatf("done_ready[%0d]", k), int'(bus.doneGo_r), int'(m_rdy));
               if (int'(outst) > max_out) max_out = int'(outst);
               if (fin) begin
                  if (exp_fin.size() == 0) begin
                     fail_now($sformatf("finished_unexpected[%0d]", k));
                  end else begin
                     chk($sformatf("finished_cycle[%0d]", k), cyc, exp_fin.pop_front());
                     chk($sformatf("finished_issued[%0d]", k), int'(issued), N);
                  end
               end
               if (bus.sourceGo_d && bus.sourceGo_r) begin
                  seen.push_back(cyc + 1);
                  if (bus.doneGo_d && outst == 8'd1) both_cnt++;
                  if (exp_xfer.size() == 0) begin
                     fail_now($sformatf("xfer_unexpected[%0d]", k));
                  end else begin
                     chk($sformatf("xfer_edge[%0d]", k), cyc + 1, exp_xfer.pop_front());
                     pend_cnt = exp_cnt.pop_front();
                  end
               end
            end
         end
      end
   end

   task automatic run(input int k, input int budget);
      int n = 0;
      start_req[k] = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      if (!m_active_v[k]) fail_now($sformatf("run_no_start[%0d]", k));
      while (m_active_v[k] && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= budget) fail_now($sformatf("run_timeout[%0d]", k));
   endtask

   initial begin
      int n;
      for (int k = 0; k < Lanes; k++) begin
         start_req[k] = 1'b0;
         rdy_rand[k]  = 1'b0;
         rdy_hold[k]  = 0;
         dly_lo[k]    = 3;
         dly_hi[k]    = 3;
         spur[k]      = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("reset_busy", int'(g_lane[0].busy), 0);
      chk("reset_valid", int'(g_lane[0].bus.sourceGo_d), 0);
      chk("reset_done_ready", int'(g_lane[0].bus.doneGo_r), 0);
      chk("reset_issued", int'(g_lane[0].issued), 0);
      chk("reset_outstanding", int'(g_lane[0].outst), 0);
      chk("reset_err_fin", int'({g_lane[0].err, g_lane[0].fin}), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;

      // Defaults, ready high, completions 3 cycles after transfer.
      run(0, 200);
      chk("basic_issued", int'(g_lane[0].issued), 4);
      chk("basic_max_outstanding_ok", int'(g_lane[0].max_out <= 2), 1);

      // Backpressure for 5 cycles once valid is up.
      rdy_hold[0] = 5;
      run(0, 200);
      chk("bp_issued", int'(g_lane[0].issued), 4);

      // Spacing with GAP=2 and ample credit.
      g_lane[1].seen.delete();
      run(1, 200);
      chk("gap_count", g_lane[1].seen.size(), 3);
      if (g_lane[1].seen.size() == 3) begin
         chk("gap_space_1", g_lane[1].seen[1] - g_lane[1].seen[0], 3);
         chk("gap_space_2", g_lane[1].seen[2] - g_lane[1].seen[1], 3);
      end

      // One-cycle completions make an issue and a completion coincide at outstanding 1.
      dly_lo[0] = 1;
      dly_hi[0] = 1;
      run(0, 200);
      chk("sim_xfer_cpl_seen", int'(g_lane[0].both_cnt > 0), 1);

      // Spurious completion in idle, then a start clears err.
      spur[0] = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("idle_cpl_err", int'(g_lane[0].err), 1);
      chk("idle_cpl_outstanding", int'(g_lane[0].outst), 0);
      run(0, 200);
      chk("err_cleared", int'(g_lane[0].err), 0);

      // Reset mid-run at issued 2 / outstanding 2.
      dly_lo[0] = 4;
      dly_hi[0] = 4;
      start_req[0] = 1'b1;
      n = 0;
      while (!(m_issued_v[0] == 2 && m_out_v[0] == 2) && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 100) fail_now("midrun_wait_timeout");
      #1 rst = 1'b1;
      #1;
      chk("midrun_rst_busy", int'(g_lane[0].busy), 0);
      chk("midrun_rst_valid", int'(g_lane[0].bus.sourceGo_d), 0);
      chk("midrun_rst_issued", int'(g_lane[0].issued), 0);
      chk("midrun_rst_outstanding", int'(g_lane[0].outst), 0);
      chk("midrun_rst_misc",
          int'({g_lane[0].err, g_lane[0].fin, g_lane[0].bus.doneGo_r}), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
      run(0, 200);
      chk("after_rst_issued", int'(g_lane[0].issued), 4);

      // Randomized runs on both lanes concurrently.
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < Lanes; k++) begin
            rdy_rand[k] = 1'b1;
            dly_lo[k] = int'($urandom_range(3, 1));
            dly_hi[k] = dly_lo[k] + int'($urandom_range(4, 0));
         end
         fork
            run(0, 400);
            run(1, 400);
         join
         repeat (int'($urandom_range(3, 0))) @(posedge clk);
         #2;
      end

      repeat (3) @(posedge clk);
      #2;
      chk("xfer_queue_empty_0", g_lane[0].exp_xfer.size(), 0);
      chk("xfer_queue_empty_1", g_lane[1].exp_xfer.size(), 0);
      chk("fin_queue_empty_0", g_lane[0].exp_fin.size(), 0);
      chk("fin_queue_empty_1", g_lane[1].exp_fin.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/go_token_source.md
# go_token_source

Upstream control stage that drives the `sourceGo` Go channel of a compute block. On a start pulse it issues a programmable number of Go tokens, obeying the valid/ready handshake, optional inter-token spacing and a cap on outstanding (issued but not completed) tokens. Completions return on a `doneGo` channel from the consumer's output. Status outputs let the bench or a top-level sequencer see progress.

## Interface
- `NUM_TOKENS`, 4: tokens issued per run, range 1..65535.
- `MAX_OUTSTANDING`, 2: credit limit, range 1..255.
- `GAP`, 0: idle cycles forced after each accepted token, range 0..255.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  one-cycle run request; sampled only in IDLE.
- `sourceGo_d`  out  1  Go token valid/data to the consumer (1 = token present).
- `sourceGo_r`  in  1  consumer ready; transfer occurs on an edge where `sourceGo_d & sourceGo_r`.
- `doneGo_d`  in  1  completion token from the consumer's result channel.
- `doneGo_r`  out  1  ready for completions.
- `busy`  out  1  high in every state except IDLE.
- `finished`  out  1  one-cycle pulse when a run completes.
- `issued_cnt`  out  16  tokens accepted by the consumer in the current or last run.
- `outstanding`  out  8  tokens accepted but not yet completed.
- `err`  out  1  sticky; set on completion underflow.

## Operation
- States: IDLE, ISSUE, GAP_WAIT, DRAIN.
- IDLE: `sourceGo_d` = 0. `start` = 1 clears `issued_cnt` and `err`, then enters ISSUE.
- ISSUE: `sourceGo_d` = 1 only while `outstanding < MAX_OUTSTANDING`. Otherwise it is 0 and the block stays in ISSUE.
  - Once asserted, `sourceGo_d` holds 1 until the transfer completes. Valid never depends combinationally on `sourceGo_r`.
- On transfer: `issued_cnt` += 1 and `outstanding` += 1. Next state:
  - DRAIN if `issued_cnt` reaches `NUM_TOKENS`;
  - else GAP_WAIT if `GAP` > 0;
  - else stay in ISSUE.
- GAP_WAIT: `sourceGo_d` = 0 for exactly `GAP` cycles (down-counter), then ISSUE.
- DRAIN: `sourceGo_d` = 0. When `outstanding` = 0, pulse `finished` for one cycle and return to IDLE.
- Completions: `doneGo_r` = 1 in every state out of reset. Each edge with `doneGo_d` = 1 decrements `outstanding`.
- Simultaneous issue transfer and completion on the same edge: `outstanding` is unchanged.
- Completion while `outstanding` = 0: ignored, counter stays 0, `err` set. This also applies in IDLE.
- `start` while `busy`: ignored, no restart, no counter change.
- Counters saturate; no wrap is reachable within the parameter ranges.

## Timing
- Reset values: `sourceGo_d` 0, `doneGo_r` 0, `busy` 0, `finished` 0, `issued_cnt` 0, `outstanding` 0, `err` 0, state IDLE.
- First edge after reset deassert: `doneGo_r` goes to 1.
- `start` sampled at edge t: `busy` = 1 and `sourceGo_d` = 1 after edge t, assuming credit is available. Latency is 1 cycle.
- With `GAP` = 0, `sourceGo_r` tied high and ample credit: one token per cycle, back-to-back.
- With `GAP` = g: accepted tokens are spaced g+1 cycles apart.
- A freed credit raises `sourceGo_d` on the cycle after the completion edge.
- `finished` is asserted the cycle after the edge on which `outstanding` becomes 0 in DRAIN. `busy` falls in the same cycle.
- `reset` mid-run: all outputs drop to their reset values asynchronously. A pending token is abandoned and not counted.
- All outputs are registered.

## Test plan
- Defaults, ready high, each completion returned 3 cycles after its transfer, `start` at cycle 2:
  - `sourceGo_d` rises at cycle 3; 4 transfers occur;
  - `outstanding` never exceeds 2;
  - `finished` pulses once; `issued_cnt` = 4; `err` = 0.
- Backpressure, `sourceGo_r` low for 5 cycles after `sourceGo_d` rises: `sourceGo_d` stays 1 throughout, `issued_cnt` stays 0, then the transfer occurs on the first edge with ready = 1.
- `GAP` = 2, `MAX_OUTSTANDING` = 8, ready high, `NUM_TOKENS` = 3: transfers on cycles t, t+3, t+6.
- Simultaneous transfer and completion with `outstanding` = 1: `outstanding` stays 1 and `issued_cnt` increments.
- `doneGo_d` pulse in IDLE: `err` = 1 and `outstanding` = 0. The next `start` clears `err`.
- `reset` asserted mid-run with `issued_cnt` = 2 and `outstanding` = 2: all outputs are 0 immediately, and a subsequent `start` runs a clean 4-token sequence.
